// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, mux selects,
// FSM states and the packed control vector produced by the output decoder.
package mc_control_fsm_pkg;

    localparam int OPC_W   = 4;
    localparam int FUNCT_W = 3;

    localparam logic [OPC_W-1:0] OP_RTYPE = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'd1;
    localparam logic [OPC_W-1:0] OP_LW    = 4'd2;
    localparam logic [OPC_W-1:0] OP_SW    = 4'd3;
    localparam logic [OPC_W-1:0] OP_BEQ   = 4'd4;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'd5;
    localparam logic [OPC_W-1:0] OP_HLT   = 4'd15;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_REGB = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_JOFF = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        ST_START, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR,
        ST_MEM_RD, ST_MEM_WR, ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_HALT
    } state_t;

    typedef struct packed {
        logic       i_or_d;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       illegal_op;
        logic       halted;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Purely combinational map from FSM state (plus mem_ready, the decoded
// illegal flag and the latched destination select) to the control vector.
module mc_output_decode
    import mc_control_fsm_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   op_illegal,
    input  logic   reg_dst_latched,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                // PC increment and IR load happen only in the cycle memory delivers
                if (mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.alu_src_b = SRCB_ONE;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                end
            end
            ST_DECODE: begin
                ctrl.alu_src_b  = SRCB_JOFF;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = op_illegal;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.retire    = mem_ready;
            end
            ST_WB_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = reg_dst_latched;
                ctrl.retire    = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.retire    = 1'b1;
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: state register, next-state logic and the reg_dst
// latch; control outputs come from mc_output_decode.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int OPCODE_BITS = OPC_W,
    parameter int FUNCT_BITS  = FUNCT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [OPCODE_BITS-1:0] opcode,
    input  logic [FUNCT_BITS-1:0]  funct,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   i_or_d,
    output logic                   mem_to_reg,
    output logic                   reg_dst,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_write,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic [1:0]             pc_source,
    output logic                   retire,
    output logic                   illegal_op,
    output logic                   halted
);

    state_t state_reg, state_next;
    logic   reg_dst_reg, reg_dst_next;
    ctrl_t  ctrl;

    // funct is consumed by the ALU control and zero by the PC gating downstream
    logic unused_inputs;
    assign unused_inputs = ^{funct, zero};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_START;
            reg_dst_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            reg_dst_reg <= reg_dst_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        reg_dst_next = reg_dst_reg;
        case (state_reg)
            ST_START:  state_next = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_next = ST_EXEC_R;
                    OP_ADDI:       state_next = ST_EXEC_I;
                    OP_LW, OP_SW:  state_next = ST_MEM_ADDR;
                    OP_BEQ:        state_next = ST_BRANCH;
                    OP_JMP:        state_next = ST_JUMP;
                    OP_HLT:        state_next = ST_HALT;
                    default:       state_next = ST_FETCH;
                endcase
            end
            ST_EXEC_R: begin
                state_next   = ST_WB_ALU;
                reg_dst_next = 1'b1;
            end
            ST_EXEC_I: begin
                state_next   = ST_WB_ALU;
                reg_dst_next = 1'b0;
            end
            // Only LW and SW reach here, and the IR has not changed since DECODE
            ST_MEM_ADDR: state_next = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready) state_next = ST_WB_MEM;
            ST_MEM_WR:   if (mem_ready) state_next = ST_FETCH;
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_next = ST_FETCH;
            ST_HALT:     state_next = ST_HALT;
            default:     state_next = ST_START;
        endcase
    end

    mc_output_decode u_decode (
        .state           (state_reg),
        .mem_ready       (mem_ready),
        .op_illegal      (!op_is_legal(opcode)),
        .reg_dst_latched (reg_dst_reg),
        .ctrl            (ctrl)
    );

    assign i_or_d        = ctrl.i_or_d;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_write     = ctrl.reg_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign retire        = ctrl.retire;
    assign illegal_op    = ctrl.illegal_op;
    assign halted        = ctrl.halted;

    a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset_n)
        !(ctrl.mem_read && ctrl.mem_write));
    a_no_regw_memw: assert property (@(posedge clk) disable iff (!reset_n)
        !(ctrl.reg_write && ctrl.mem_write));

endmodule
